// File: rtl/halt_ctrl.sv
// Sequenced halt controller beside the IF stage: detects HALT or an external
// request, drains the pipeline, then holds in HALTED until resume or single-step.
module halt_ctrl #(
    parameter int                 DATA_W       = 32,
    parameter logic [DATA_W-1:0]  HALT_INSTR   = 32'hFFFF_FFFF,
    parameter int                 DRAIN_CYCLES = 3,
    parameter int                 PC_STEP      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    input  logic [DATA_W-1:0] instr,
    input  logic [DATA_W-1:0] pc,
    input  logic              ext_halt_req,
    input  logic              resume,
    input  logic              step,
    output logic              halt,
    output logic              halted,
    output logic [DATA_W-1:0] halt_pc,
    output logic [DATA_W-1:0] resume_pc,
    output logic [1:0]        halt_cause,
    output logic [15:0]       halt_count,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2,
        ST_STEP   = 2'd3
    } state_t;

    localparam logic [7:0]  CNT_LOAD   = 8'(DRAIN_CYCLES - 1);
    localparam logic [1:0]  CAUSE_NONE = 2'b00;
    localparam logic [1:0]  CAUSE_INSTR = 2'b01;
    localparam logic [1:0]  CAUSE_EXT  = 2'b10;
    localparam logic [1:0]  CAUSE_STEP = 2'b11;

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] halt_pc_q, halt_pc_d;
    logic [1:0]        cause_q, cause_d;
    logic [15:0]       count_q, count_d;
    logic              halted_q;
    logic              hit;

    assign hit = instr_valid && (instr == HALT_INSTR);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        halt_pc_d = halt_pc_q;
        cause_d   = cause_q;
        count_d   = count_q;
        halt      = 1'b0;
        case (state_q)
            ST_RUN: begin
                // Stall the triggering cycle itself so the HALT never advances.
                halt = hit | ext_halt_req;
                if (hit) begin
                    halt_pc_d = pc;
                    cause_d   = CAUSE_INSTR;
                    cnt_d     = CNT_LOAD;
                    state_d   = ST_DRAIN;
                end else if (ext_halt_req) begin
                    halt_pc_d = pc;
                    cause_d   = CAUSE_EXT;
                    cnt_d     = CNT_LOAD;
                    state_d   = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                halt = 1'b1;
                if (cnt_q == 8'd0) begin
                    state_d = ST_HALTED;
                    if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_HALTED: begin
                halt = 1'b1;
                if (resume) begin
                    cause_d = CAUSE_NONE;
                    state_d = ST_RUN;
                end else if (step) begin
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                // One fetch slot is opened; an empty slot keeps the previous halt info.
                if (instr_valid) begin
                    halt_pc_d = pc;
                    cause_d   = hit ? CAUSE_INSTR : CAUSE_STEP;
                end
                cnt_d   = CNT_LOAD;
                state_d = ST_DRAIN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            cnt_q     <= 8'd0;
            halt_pc_q <= '0;
            cause_q   <= CAUSE_NONE;
            count_q   <= 16'd0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            halt_pc_q <= halt_pc_d;
            cause_q   <= cause_d;
            count_q   <= count_d;
            halted_q  <= (state_d == ST_HALTED);
        end
    end

    assign halted     = halted_q;
    assign halt_pc    = (state_q == ST_RUN) ? '0 : halt_pc_q;
    assign resume_pc  = (cause_q == CAUSE_INSTR || cause_q == CAUSE_STEP)
                        ? halt_pc + DATA_W'(PC_STEP) : halt_pc;
    assign halt_cause = cause_q;
    assign halt_count = count_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_halt_ctrl.sv
// Scenario bench for halt_ctrl: each task drives one feature; a scoreboard
// holds the expected halt snapshot and is checked when halted rises.
module tb_halt_ctrl;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        ext_halt_req;
    logic        resume;
    logic        step;
    logic        halt;
    logic        halted;
    logic [31:0] halt_pc;
    logic [31:0] resume_pc;
    logic [1:0]  halt_cause;
    logic [15:0] halt_count;
    logic [1:0]  dbg_state;

    // Snapshot layout: {halt_pc, resume_pc, cause, count}
    logic [81:0] exp_q[$];
    logic [15:0] exp_count;
    logic        halted_prev;
    int          passed;
    int          total;

    halt_ctrl dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr), .pc(pc),
        .ext_halt_req(ext_halt_req), .resume(resume), .step(step), .halt(halt),
        .halted(halted), .halt_pc(halt_pc), .resume_pc(resume_pc),
        .halt_cause(halt_cause), .halt_count(halt_count), .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: compare the full snapshot on every entry into HALTED.
    initial halted_prev = 1'b0;
    always @(negedge clk) begin
        if (rst_n && halted && !halted_prev) begin
            total++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_halted: got pc=%h cause=%b count=%h, no entry expected",
                         halt_pc, halt_cause, halt_count);
            end else begin
                logic [81:0] e;
                e = exp_q.pop_front();
                if ({halt_pc, resume_pc, halt_cause, halt_count} !== e)
                    $display("FAIL halted_snapshot: got pc=%h rpc=%h cause=%b count=%h want pc=%h rpc=%h cause=%b count=%h",
                             halt_pc, resume_pc, halt_cause, halt_count,
                             e[81:50], e[49:18], e[17:16], e[15:0]);
                else passed++;
            end
        end
        halted_prev = halted;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        instr_valid = 1'b0; instr = 32'h0; pc = 32'h0;
        ext_halt_req = 1'b0; resume = 1'b0; step = 1'b0;
    endtask

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Presents a trigger for one RUN cycle and records the expected halt.
    task automatic trigger(input logic use_hit, input logic use_ext, input logic [31:0] p);
        logic [1:0] c;
        instr_valid = use_hit; instr = use_hit ? 32'hFFFF_FFFF : 32'h0000_0013;
        ext_halt_req = use_ext; pc = p;
        #1;
        total++;
        if (halt !== 1'b1) $display("FAIL trigger_halt: got %b want 1 at pc=%h", halt, p);
        else passed++;
        c = use_hit ? 2'b01 : 2'b10;
        exp_count = sat_inc(exp_count);
        exp_q.push_back({p, use_hit ? p + 32'd4 : p, c, exp_count});
        cyc();
        idle_inputs();
    endtask

    task automatic wait_halted();
        for (int i = 0; i < 20 && !halted; i++) cyc();
        total++;
        if (halted !== 1'b1) $display("FAIL wait_halted: got %b want 1 within 20 cycles", halted);
        else passed++;
    endtask

    task automatic do_resume();
        resume = 1'b1;
        cyc();
        resume = 1'b0;
        #1;
        total++;
        if ({halt, halted, halt_pc, resume_pc, halt_cause, dbg_state} !== {1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 2'd0})
            $display("FAIL resume_run: got halt=%b halted=%b pc=%h rpc=%h cause=%b st=%0d want all 0",
                     halt, halted, halt_pc, resume_pc, halt_cause, dbg_state);
        else passed++;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        cyc(); cyc();
        total++;
        if ({halt, halted, halt_pc, resume_pc, halt_cause, halt_count, dbg_state} !== 86'h0)
            $display("FAIL reset_outputs: got halt=%b halted=%b pc=%h rpc=%h cause=%b count=%h st=%0d want all 0",
                     halt, halted, halt_pc, resume_pc, halt_cause, halt_count, dbg_state);
        else passed++;
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_halt_detect();
        trigger(1'b1, 1'b0, 32'h0000_0040);
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({halt, halted, dbg_state} !== {1'b1, 1'b0, 2'd1})
                $display("FAIL drain_cycle%0d: got halt=%b halted=%b st=%0d want 1 0 1",
                         i, halt, halted, dbg_state);
            else passed++;
            cyc();
        end
        total++;
        if ({halt, halted, halt_pc, resume_pc} !== {1'b1, 1'b1, 32'h40, 32'h44})
            $display("FAIL halted_at_t4: got halt=%b halted=%b pc=%h rpc=%h want 1 1 40 44",
                     halt, halted, halt_pc, resume_pc);
        else passed++;
        do_resume();
    endtask

    task automatic test_priority();
        trigger(1'b1, 1'b1, 32'h0000_0080);
        wait_halted();
        total++;
        if (halt_cause !== 2'b01) $display("FAIL priority_cause: got %b want 01", halt_cause);
        else passed++;
        do_resume();
    endtask

    task automatic test_ext();
        trigger(1'b0, 1'b1, 32'h0000_0100);
        // Requests during DRAIN must not disturb the drain.
        ext_halt_req = 1'b1; resume = 1'b1; step = 1'b1;
        cyc();
        idle_inputs();
        wait_halted();
        total++;
        if (resume_pc !== 32'h100) $display("FAIL ext_resume_pc: got %h want 00000100", resume_pc);
        else passed++;
    endtask

    task automatic test_resume_step();
        step = 1'b1;
        do_resume();
        step = 1'b0;
    endtask

    task automatic test_single_step();
        trigger(1'b0, 1'b1, 32'h0000_0200);
        wait_halted();
        step = 1'b1;
        cyc();
        step = 1'b0; instr_valid = 1'b1; instr = 32'h0000_0013; pc = 32'h0000_0200;
        #1;
        total++;
        if ({halt, halted, dbg_state} !== {1'b0, 1'b0, 2'd3})
            $display("FAIL step_open: got halt=%b halted=%b st=%0d want 0 0 3", halt, halted, dbg_state);
        else passed++;
        exp_count = sat_inc(exp_count);
        exp_q.push_back({32'h200, 32'h204, 2'b11, exp_count});
        cyc();
        idle_inputs();
        total++;
        if ({halt, dbg_state} !== {1'b1, 2'd1})
            $display("FAIL step_one_cycle: got halt=%b st=%0d want 1 1", halt, dbg_state);
        else passed++;
        wait_halted();
        do_resume();
    endtask

    task automatic test_boundaries();
        instr_valid = 1'b0; instr = 32'hFFFF_FFFF; pc = 32'h0000_0300;
        #1;
        total++;
        if (halt !== 1'b0) $display("FAIL invalid_no_halt: got %b want 0", halt);
        else passed++;
        cyc();
        total++;
        if ({dbg_state, halt_pc} !== {2'd0, 32'h0})
            $display("FAIL invalid_stays_run: got st=%0d pc=%h want 0 0", dbg_state, halt_pc);
        else passed++;
        idle_inputs();
        trigger(1'b1, 1'b0, 32'hFFFF_FFFC);
        wait_halted();
        total++;
        if (resume_pc !== 32'h0) $display("FAIL wrap_resume_pc: got %h want 00000000", resume_pc);
        else passed++;
        do_resume();
    endtask

    task automatic test_saturation();
        force dut.count_q = 16'hFFFE;
        #1;
        release dut.count_q;
        exp_count = 16'hFFFE;
        for (int i = 0; i < 2; i++) begin
            trigger(1'b1, 1'b0, 32'h0000_1000 + 32'(i * 16));
            wait_halted();
            total++;
            if (halt_count !== 16'hFFFF) $display("FAIL sat_count%0d: got %h want ffff", i, halt_count);
            else passed++;
            do_resume();
        end
    endtask

    task automatic test_back_to_back();
        trigger(1'b0, 1'b1, 32'h0000_0400);
        wait_halted();
        resume = 1'b1; ext_halt_req = 1'b1; pc = 32'h0000_0500;
        cyc();
        resume = 1'b0;
        #1;
        total++;
        if ({halt, halted, dbg_state} !== {1'b1, 1'b0, 2'd0})
            $display("FAIL rehalt_first_run: got halt=%b halted=%b st=%0d want 1 0 0", halt, halted, dbg_state);
        else passed++;
        exp_count = sat_inc(exp_count);
        exp_q.push_back({32'h500, 32'h500, 2'b10, exp_count});
        cyc();
        idle_inputs();
        wait_halted();
        do_resume();
    endtask

    task automatic test_reset_mid();
        trigger(1'b1, 1'b0, 32'h0000_0600);
        cyc();
        rst_n = 1'b0;
        cyc();
        total++;
        if ({halt, halted, halt_pc, resume_pc, halt_cause, halt_count, dbg_state} !== 86'h0)
            $display("FAIL reset_mid: got halt=%b halted=%b pc=%h rpc=%h cause=%b count=%h st=%0d want all 0",
                     halt, halted, halt_pc, resume_pc, halt_cause, halt_count, dbg_state);
        else passed++;
        rst_n = 1'b1;
        exp_q.delete();
        exp_count = 16'd0;
        cyc();
        test_halt_detect();
    endtask

    initial begin
        passed = 0;
        total = 0;
        exp_count = 16'd0;
        test_reset();
        test_halt_detect();
        test_priority();
        test_ext();
        test_resume_step();
        test_single_step();
        test_boundaries();
        test_saturation();
        test_back_to_back();
        test_reset_mid();
        cyc();
        total++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/halt_ctrl.md
Name: halt_ctrl

Overview:
Parametrised halt controller for the RISC-V pipeline. It replaces the purely combinational halt detector with a sequenced controller that:
- detects a configurable HALT encoding or an external halt request,
- stalls the frontend and drains in-flight instructions for a fixed number of cycles,
- reports a quiesced state, supports resume and single-step, and supplies the restart PC.

It sits beside the IF stage and drives the PC/IF stall and the debug status outputs.

Parameters:
DATA_W, 32, width of instruction and PC buses
HALT_INSTR, 32'hFFFF_FFFF, instruction encoding treated as HALT
DRAIN_CYCLES, 3, cycles spent in DRAIN before HALTED (legal range 1..255)
PC_STEP, 4, byte increment from the halt PC to the resume PC after an instruction-caused or step halt

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
instr_valid  in  1  instr/pc carry a valid fetched instruction this cycle
instr  in  DATA_W  instruction at IF
pc  in  DATA_W  PC of instr
ext_halt_req  in  1  external/debugger halt request (level)
resume  in  1  resume request, sampled only in HALTED
step  in  1  single-step request, sampled only in HALTED
halt  out  1  frontend stall (PC hold, IF bubble)
halted  out  1  pipeline fully drained and stopped
halt_pc  out  DATA_W  captured halt PC; reads 0 in RUN
resume_pc  out  DATA_W  PC the frontend reloads on resume
halt_cause  out  2  00 none, 01 HALT instruction, 10 external, 11 step complete
halt_count  out  16  saturating count of entries into HALTED

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=RUN; counter, halt_pc reg, cause and halt_count all cleared.
  - All outputs read 0.
  - Reset during DRAIN/HALTED/STEP returns to RUN with no intermediate state.
- States: RUN, DRAIN, HALTED, STEP, registered, 2-bit encoding.
- hit = instr_valid && (instr == HALT_INSTR). With instr_valid low, no match regardless of instr.
- RUN:
  - halt is combinational: halt = hit | ext_halt_req, so the triggering cycle is already stalled.
  - On hit: halt_pc<=pc, cause<=01, cnt<=DRAIN_CYCLES-1, go to DRAIN.
  - Else on ext_halt_req: halt_pc<=pc, cause<=10, same counter load, go to DRAIN.
  - hit and ext_halt_req in the same cycle: hit wins, cause=01.
- DRAIN:
  - halt=1, halted=0.
  - cnt decrements each cycle. At cnt==0 go to HALTED next edge, so exactly DRAIN_CYCLES cycles are spent in DRAIN.
  - resume, step and ext_halt_req are ignored.
- HALTED:
  - halt=1, halted=1.
  - halt_count increments on each DRAIN->HALTED transition and saturates at 16'hFFFF.
  - resume=1 -> RUN next edge; halt and halted deassert in the first RUN cycle; cause<=00.
  - step=1 (resume=0) -> STEP.
  - resume and step together: resume wins.
  - ext_halt_req still high after resume re-halts on the first RUN cycle; this is legal.
- STEP:
  - Exactly one cycle; halt=0, halted=0, one instruction is fetched.
  - If instr_valid: halt_pc<=pc; cause<=01 if hit, else 11.
  - If !instr_valid: halt_pc and cause are held.
  - Always go to DRAIN with the counter loaded (same rule as RUN).
- halt_pc: registered value when state!=RUN, 0 in RUN.
- resume_pc: halt_pc + PC_STEP when cause is 01 or 11, halt_pc when cause is 10. Unsigned add modulo 2^DATA_W, so 32'hFFFF_FFFC + 4 = 0.
- halted and halt_count are registered outputs. halt is combinational only through hit/ext_halt_req in RUN.

Test Plan:
- HALT detection: reset; RUN; in cycle T, instr=FFFF_FFFF, valid=1, pc=0x0000_0040 -> halt=1 in T; DRAIN for 3 cycles; halted=1 from T+4; halt_pc=0x40, resume_pc=0x44, cause=01, halt_count=1.
- Priority and external halt: same cycle hit (pc=0x80) + ext_halt_req -> cause=01. Separate run with ext_halt_req only at pc=0x100 -> cause=10, resume_pc=0x100.
- Resume/step: in HALTED, assert resume+step together -> RUN next cycle, halt=0, halted=0, halt_pc reads 0.
- Single step: halt at pc 0x200, then step with valid instr at pc=0x200 -> exactly one cycle with halt=0; halted again after 3 DRAIN cycles; cause=11, resume_pc=0x204, halt_count=2.
- Boundaries:
  - HALT with instr_valid=0 -> no halt.
  - HALT at pc=FFFF_FFFC -> resume_pc=0.
  - With halt_count forced to 0xFFFF via repeated halts, it stays 0xFFFF.
- Reset mid-operation: rst_n low in the second DRAIN cycle -> next cycle all outputs 0, state RUN; a later HALT behaves as in the first scenario with halt_count=1.
